// File: rtl/nvdla_package.sv
// Shared types and widths for the NVDLA CSB master and its helpers.
package nvdla_package;
   localparam int CSB_ADDR_W = 16;
   localparam int CSB_DATA_W = 32;
   localparam int WAIT_CNT_W = 16;

   typedef enum logic [2:0] {
      CSB_IDLE,
      CSB_REQ,
      CSB_WAIT_RSP,
      CSB_WAIT_INTR,
      CSB_DONE
   } csb_state_t;
endpackage

// File: rtl/nvdla_csb_master_if.sv
// csb2nvdla request channel and nvdla2csb response channel.
interface nvdla_csb_master_if
   import nvdla_package::*;
   ();
   logic                  csb2nvdla_valid;
   logic                  csb2nvdla_ready;
   logic [CSB_ADDR_W-1:0] csb2nvdla_addr;
   logic [CSB_DATA_W-1:0] csb2nvdla_wdat;
   logic                  csb2nvdla_write;
   logic                  csb2nvdla_nposted;
   logic                  nvdla2csb_valid;
   logic [CSB_DATA_W-1:0] nvdla2csb_data;
   logic                  nvdla2csb_wr_complete;

   modport master (
      output csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
      input  csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete
   );

   modport slave (
      input  csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
      output csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete
   );
endinterface

// File: rtl/nvdla_wait_counter.sv
// Wait-state cycle counter; limit_o flags the last allowed cycle of a wait.
module nvdla_wait_counter
   import nvdla_package::*;
#(
   parameter int unsigned LIMIT = 65535
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic limit_o
);
   localparam logic [WAIT_CNT_W-1:0] LIMIT_M1 = WAIT_CNT_W'(LIMIT - 1);

   logic [WAIT_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + WAIT_CNT_W'(1);
      end
   end

   assign limit_o = en_i && (cnt_q == LIMIT_M1);
endmodule

// File: rtl/nvdla_csb_master.sv
// Single-outstanding CSB register-access engine with optional interrupt wait.
// state     | meaning
// IDLE      | ready for a request from the control FSM
// REQ       | csb2nvdla request driven, waiting for ready
// WAIT_RSP  | waiting for read data or non-posted write completion
// WAIT_INTR | waiting for nvdla_intr_i
// DONE      | one-cycle response pulse
module nvdla_csb_master
   import nvdla_package::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter bit          NPOSTED_WRITES = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [CSB_ADDR_W-1:0] req_addr_i,
   input  logic [CSB_DATA_W-1:0] req_wdat_i,
   input  logic                  req_write_i,
   input  logic                  req_wait_intr_i,
   output logic                  rsp_valid_o,
   output logic [CSB_DATA_W-1:0] rsp_rdata_o,
   output logic                  rsp_error_o,
   output logic                  busy_o,
   nvdla_csb_master_if.master    csb,
   input  logic                  nvdla_intr_i
);
   csb_state_t            state_q, state_d;
   logic                  csb_valid_q;
   logic [CSB_ADDR_W-1:0] addr_q;
   logic [CSB_DATA_W-1:0] wdat_q;
   logic                  write_q;
   logic                  nposted_q;
   logic                  wait_intr_q;
   logic                  rsp_valid_q;
   logic [CSB_DATA_W-1:0] rdata_q;
   logic                  error_q;
   logic                  srst;
   logic                  in_wait;
   logic                  limit;
   logic                  rsp_evt;
   logic                  cap_rdata;
   logic                  timeout;

   assign srst    = rst_i || clear_i;
   assign in_wait = (state_q == CSB_WAIT_RSP) || (state_q == CSB_WAIT_INTR);
   // Mismatched response kinds are ignored: reads only see valid, writes only completion.
   assign rsp_evt = write_q ? csb.nvdla2csb_wr_complete : csb.nvdla2csb_valid;

   nvdla_wait_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_counter (
      .clk_i   (clk_i),
      .rst_i   (srst),
      .clr_i   (state_d != state_q),
      .en_i    (in_wait),
      .limit_o (limit)
   );

   always_comb begin
      state_d   = state_q;
      cap_rdata = 1'b0;
      timeout   = 1'b0;
      unique case (state_q)
         CSB_IDLE: begin
            if (req_valid_i) state_d = CSB_REQ;
         end
         CSB_REQ: begin
            if (csb.csb2nvdla_ready) begin
               if (write_q && !NPOSTED_WRITES) state_d = wait_intr_q ? CSB_WAIT_INTR : CSB_DONE;
               else                            state_d = CSB_WAIT_RSP;
            end
         end
         CSB_WAIT_RSP: begin
            if (rsp_evt) begin
               cap_rdata = !write_q;
               state_d   = wait_intr_q ? CSB_WAIT_INTR : CSB_DONE;
            end else if (limit) begin
               timeout = 1'b1;
               state_d = CSB_DONE;
            end
         end
         CSB_WAIT_INTR: begin
            if (nvdla_intr_i) begin
               state_d = CSB_DONE;
            end else if (limit) begin
               timeout = 1'b1;
               state_d = CSB_DONE;
            end
         end
         CSB_DONE: state_d = CSB_IDLE;
         default:  state_d = CSB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst) begin
         state_q     <= CSB_IDLE;
         csb_valid_q <= 1'b0;
         addr_q      <= '0;
         wdat_q      <= '0;
         write_q     <= 1'b0;
         nposted_q   <= 1'b0;
         wait_intr_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         csb_valid_q <= (state_d == CSB_REQ);
         rsp_valid_q <= (state_d == CSB_DONE);
         if ((state_q == CSB_IDLE) && req_valid_i) begin
            addr_q      <= req_addr_i;
            wdat_q      <= req_wdat_i;
            write_q     <= req_write_i;
            nposted_q   <= req_write_i && NPOSTED_WRITES;
            wait_intr_q <= req_wait_intr_i;
            rdata_q     <= '0;
            error_q     <= 1'b0;
         end
         if (cap_rdata) rdata_q <= csb.nvdla2csb_data;
         if (timeout)   error_q <= 1'b1;
      end
   end

   assign req_ready_o           = (state_q == CSB_IDLE);
   assign busy_o                = (state_q != CSB_IDLE);
   assign rsp_valid_o           = rsp_valid_q;
   assign rsp_rdata_o           = rdata_q;
   assign rsp_error_o           = error_q;
   assign csb.csb2nvdla_valid   = csb_valid_q;
   assign csb.csb2nvdla_addr    = addr_q;
   assign csb.csb2nvdla_wdat    = wdat_q;
   assign csb.csb2nvdla_write   = write_q;
   assign csb.csb2nvdla_nposted = nposted_q;
endmodule

// File: tb/tb_nvdla_csb_master.sv
// Scenario bench for nvdla_csb_master; responses are matched against a scoreboard queue.
module tb_nvdla_csb_master;
   localparam int TO = 24;

   typedef struct {
      logic [31:0] rdata;
      logic        error;
      int          cyc;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        clear_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [15:0] req_addr_i = '0;
   logic [31:0] req_wdat_i = '0;
   logic        req_write_i = 1'b0;
   logic        req_wait_intr_i = 1'b0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_error_o;
   logic        busy_o;
   logic        nvdla_intr_i = 1'b0;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t sb[$];

   nvdla_csb_master_if csb_if ();

   nvdla_csb_master #(
      .TIMEOUT_CYCLES (TO),
      .NPOSTED_WRITES (1'b1)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .clear_i         (clear_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_addr_i      (req_addr_i),
      .req_wdat_i      (req_wdat_i),
      .req_write_i     (req_write_i),
      .req_wait_intr_i (req_wait_intr_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_rdata_o     (rsp_rdata_o),
      .rsp_error_o     (rsp_error_o),
      .busy_o          (busy_o),
      .csb             (csb_if.master),
      .nvdla_intr_i    (nvdla_intr_i)
   );

   always #5 clk_i = ~clk_i;

   // Advance to the next falling edge and retire any response against the scoreboard.
   task automatic tick();
      exp_t e;
      @(negedge clk_i);
      cyc++;
      if (rsp_valid_o === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: rsp_valid_o=1 at cycle %0d, required no response", cyc);
         end else begin
            e = sb.pop_front();
            if (rsp_rdata_o !== e.rdata || rsp_error_o !== e.error || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL rsp_match: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                        rsp_rdata_o, rsp_error_o, cyc, e.rdata, e.error, e.cyc);
            end
         end
      end
   endtask

   task automatic send(input logic [15:0] a, input logic [31:0] d, input logic w, input logic wi);
      req_addr_i      = a;
      req_wdat_i      = d;
      req_write_i     = w;
      req_wait_intr_i = wi;
      req_valid_i     = 1'b1;
      tick();
      req_valid_i     = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 ||
          rsp_error_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rsp: got rdy=%b busy=%b rv=%b rd=%h err=%b, required 1 0 0 0 0",
                  req_ready_o, busy_o, rsp_valid_o, rsp_rdata_o, rsp_error_o);
      end
      n_checks++;
      if (csb_if.csb2nvdla_valid !== 1'b0 || csb_if.csb2nvdla_addr !== 16'h0 || csb_if.csb2nvdla_wdat !== 32'h0 ||
          csb_if.csb2nvdla_write !== 1'b0 || csb_if.csb2nvdla_nposted !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_csb: got v=%b a=%h d=%h w=%b np=%b, required all zero",
                  csb_if.csb2nvdla_valid, csb_if.csb2nvdla_addr, csb_if.csb2nvdla_wdat,
                  csb_if.csb2nvdla_write, csb_if.csb2nvdla_nposted);
      end
      rst_i = 1'b0;
      tick();
      n_checks++;
      if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got rdy=%b busy=%b, required 1 0", req_ready_o, busy_o);
      end
   endtask

   task automatic test_read();
      sb.push_back('{32'hDEADBEEF, 1'b0, cyc + 7});
      send(16'h1234, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (csb_if.csb2nvdla_valid !== 1'b1 || csb_if.csb2nvdla_addr !== 16'h1234 || csb_if.csb2nvdla_write !== 1'b0) begin
            n_fail++;
            $display("FAIL read_req_hold[%0d]: got v=%b a=%h w=%b, required 1 1234 0", i,
                     csb_if.csb2nvdla_valid, csb_if.csb2nvdla_addr, csb_if.csb2nvdla_write);
         end
         csb_if.csb2nvdla_ready = (i == 3);
         tick();
      end
      csb_if.csb2nvdla_ready = 1'b0;
      n_checks++;
      if (csb_if.csb2nvdla_valid !== 1'b0 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL read_after_hs: got v=%b busy=%b, required 0 1", csb_if.csb2nvdla_valid, busy_o);
      end
      tick();
      csb_if.nvdla2csb_valid = 1'b1;
      csb_if.nvdla2csb_data  = 32'hDEADBEEF;
      tick();
      csb_if.nvdla2csb_valid = 1'b0;
      csb_if.nvdla2csb_data  = 32'h0;
      tick();
      n_checks++;
      if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'hDEADBEEF || req_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL read_hold: got rv=%b rd=%h rdy=%b, required 0 deadbeef 1", rsp_valid_o, rsp_rdata_o, req_ready_o);
      end
   endtask

   task automatic test_npwrite();
      sb.push_back('{32'h0, 1'b0, cyc + 7});
      send(16'h0040, 32'hA5A5A5A5, 1'b1, 1'b0);
      n_checks++;
      if (csb_if.csb2nvdla_nposted !== 1'b1 || csb_if.csb2nvdla_write !== 1'b1 ||
          csb_if.csb2nvdla_addr !== 16'h0040 || csb_if.csb2nvdla_wdat !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL npwrite_req: got np=%b w=%b a=%h d=%h, required 1 1 0040 a5a5a5a5",
                  csb_if.csb2nvdla_nposted, csb_if.csb2nvdla_write, csb_if.csb2nvdla_addr, csb_if.csb2nvdla_wdat);
      end
      csb_if.csb2nvdla_ready = 1'b1;
      tick();
      csb_if.csb2nvdla_ready = 1'b0;
      tick();
      csb_if.nvdla2csb_valid = 1'b1;
      csb_if.nvdla2csb_data  = 32'hFFFFFFFF;
      tick();
      csb_if.nvdla2csb_valid = 1'b0;
      tick();
      tick();
      csb_if.nvdla2csb_wr_complete = 1'b1;
      tick();
      csb_if.nvdla2csb_wr_complete = 1'b0;
      tick();
   endtask

   task automatic test_wait_intr();
      sb.push_back('{32'h0, 1'b0, cyc + 23});
      send(16'h0080, 32'h1, 1'b1, 1'b1);
      csb_if.csb2nvdla_ready = 1'b1;
      tick();
      csb_if.csb2nvdla_ready = 1'b0;
      csb_if.nvdla2csb_wr_complete = 1'b1;
      tick();
      csb_if.nvdla2csb_wr_complete = 1'b0;
      n_checks++;
      if (busy_o !== 1'b1 || req_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL intr_busy: got busy=%b rdy=%b, required 1 0", busy_o, req_ready_o);
      end
      repeat (19) tick();
      nvdla_intr_i = 1'b1;
      tick();
      nvdla_intr_i = 1'b0;
      tick();
      // Interrupt already high when WAIT_INTR is entered.
      sb.push_back('{32'h0BADF00D, 1'b0, cyc + 4});
      nvdla_intr_i = 1'b1;
      send(16'h0090, 32'h0, 1'b0, 1'b1);
      csb_if.csb2nvdla_ready = 1'b1;
      tick();
      csb_if.csb2nvdla_ready = 1'b0;
      csb_if.nvdla2csb_valid = 1'b1;
      csb_if.nvdla2csb_data  = 32'h0BADF00D;
      tick();
      csb_if.nvdla2csb_valid = 1'b0;
      tick();
      nvdla_intr_i = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      sb.push_back('{32'h0, 1'b1, cyc + 2 + TO});
      send(16'h0200, 32'h0, 1'b0, 1'b0);
      csb_if.csb2nvdla_ready = 1'b1;
      tick();
      csb_if.csb2nvdla_ready = 1'b0;
      repeat (TO) tick();
      tick();
      n_checks++;
      if (rsp_error_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_hold: got err=%b rv=%b, required 1 0", rsp_error_o, rsp_valid_o);
      end
      // Data arriving on the limit cycle wins over the timeout.
      sb.push_back('{32'hCAFE0001, 1'b0, cyc + 2 + TO});
      send(16'h0204, 32'h0, 1'b0, 1'b0);
      n_checks++;
      if (rsp_error_o !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_err_clear: got err=%b, required 0", rsp_error_o);
      end
      csb_if.csb2nvdla_ready = 1'b1;
      tick();
      csb_if.csb2nvdla_ready = 1'b0;
      repeat (TO - 1) tick();
      csb_if.nvdla2csb_valid = 1'b1;
      csb_if.nvdla2csb_data  = 32'hCAFE0001;
      tick();
      csb_if.nvdla2csb_valid = 1'b0;
      tick();
      // Missing interrupt times out in WAIT_INTR.
      sb.push_back('{32'h0, 1'b1, cyc + 3 + TO});
      send(16'h0208, 32'h5, 1'b1, 1'b1);
      csb_if.csb2nvdla_ready = 1'b1;
      tick();
      csb_if.csb2nvdla_ready = 1'b0;
      csb_if.nvdla2csb_wr_complete = 1'b1;
      tick();
      csb_if.nvdla2csb_wr_complete = 1'b0;
      repeat (TO + 1) tick();
   endtask

   task automatic test_clear();
      send(16'h0300, 32'h0, 1'b0, 1'b0);
      csb_if.csb2nvdla_ready = 1'b1;
      tick();
      csb_if.csb2nvdla_ready = 1'b0;
      tick();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      n_checks++;
      if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || csb_if.csb2nvdla_valid !== 1'b0 ||
          csb_if.csb2nvdla_addr !== 16'h0 || rsp_rdata_o !== 32'h0 || rsp_error_o !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_state: got rdy=%b busy=%b rv=%b cv=%b a=%h rd=%h err=%b, required 1 0 0 0 0000 0 0",
                  req_ready_o, busy_o, rsp_valid_o, csb_if.csb2nvdla_valid, csb_if.csb2nvdla_addr,
                  rsp_rdata_o, rsp_error_o);
      end
      csb_if.nvdla2csb_valid = 1'b1;
      csb_if.nvdla2csb_data  = 32'h77777777;
      tick();
      csb_if.nvdla2csb_valid = 1'b0;
      tick();
      tick();
      n_checks++;
      if (busy_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL clear_late_data: got busy=%b rd=%h, required 0 0", busy_o, rsp_rdata_o);
      end
   endtask

   task automatic test_spurious();
      csb_if.nvdla2csb_valid       = 1'b1;
      csb_if.nvdla2csb_data        = 32'h11111111;
      csb_if.nvdla2csb_wr_complete = 1'b1;
      tick();
      tick();
      csb_if.nvdla2csb_valid       = 1'b0;
      csb_if.nvdla2csb_wr_complete = 1'b0;
      tick();
      n_checks++;
      if (rsp_rdata_o !== 32'h0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL spurious_idle: got rd=%h busy=%b, required 0 0", rsp_rdata_o, busy_o);
      end
      sb.push_back('{32'h22222222, 1'b0, cyc + 3});
      send(16'h0100, 32'h0, 1'b0, 1'b0);
      csb_if.csb2nvdla_ready = 1'b1;
      tick();
      csb_if.csb2nvdla_ready = 1'b0;
      csb_if.nvdla2csb_valid = 1'b1;
      csb_if.nvdla2csb_data  = 32'h22222222;
      tick();
      csb_if.nvdla2csb_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      sb.push_back('{32'h0000D001, 1'b0, cyc + 3});
      sb.push_back('{32'h0000D002, 1'b0, cyc + 7});
      req_addr_i      = 16'h0A00;
      req_write_i     = 1'b0;
      req_wait_intr_i = 1'b0;
      req_valid_i     = 1'b1;
      tick();
      req_addr_i = 16'h0B00;
      csb_if.csb2nvdla_ready = 1'b1;
      n_checks++;
      if (csb_if.csb2nvdla_addr !== 16'h0A00) begin
         n_fail++;
         $display("FAIL b2b_first_addr: got %h, required 0a00", csb_if.csb2nvdla_addr);
      end
      tick();
      csb_if.csb2nvdla_ready = 1'b0;
      csb_if.nvdla2csb_valid = 1'b1;
      csb_if.nvdla2csb_data  = 32'h0000D001;
      tick();
      csb_if.nvdla2csb_valid = 1'b0;
      n_checks++;
      if (req_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_done_not_ready: got rdy=%b, required 0", req_ready_o);
      end
      tick();
      n_checks++;
      if (req_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_idle_ready: got rdy=%b, required 1", req_ready_o);
      end
      tick();
      req_valid_i = 1'b0;
      n_checks++;
      if (csb_if.csb2nvdla_valid !== 1'b1 || csb_if.csb2nvdla_addr !== 16'h0B00) begin
         n_fail++;
         $display("FAIL b2b_second_req: got v=%b a=%h, required 1 0b00", csb_if.csb2nvdla_valid, csb_if.csb2nvdla_addr);
      end
      csb_if.csb2nvdla_ready = 1'b1;
      tick();
      csb_if.csb2nvdla_ready = 1'b0;
      csb_if.nvdla2csb_valid = 1'b1;
      csb_if.nvdla2csb_data  = 32'h0000D002;
      tick();
      csb_if.nvdla2csb_valid = 1'b0;
      tick();
   endtask

   initial begin
      csb_if.csb2nvdla_ready       = 1'b0;
      csb_if.nvdla2csb_valid       = 1'b0;
      csb_if.nvdla2csb_data        = 32'h0;
      csb_if.nvdla2csb_wr_complete = 1'b0;
      test_reset();
      test_read();
      test_npwrite();
      test_wait_intr();
      test_timeout();
      test_clear();
      test_spurious();
      test_back_to_back();
      repeat (3) tick();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL rsp_missing: %0d responses outstanding, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
